// File: rtl/gray_code_subtractor_pipe.sv
// gray_code_subtractor_pipe
// Three-stage, valid/ready handshaked subtractor on reflected-binary Gray
// operands: diff = a - b - bi (modulo 2^WIDTH), bo = borrow out.
//   S1: Gray -> binary conversion of both operands, borrow-in captured
//   S2: WIDTH+1 bit binary subtraction, borrow taken from the extra MSB
//   S3: binary -> Gray conversion, registered outputs
// Optional macro DIFF_STATS_EN adds a saturating completed-output counter
// (txn_count). Datapath and handshake timing do not depend on the macro.
module gray_code_subtractor_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bo
`ifdef DIFF_STATS_EN
   ,
   output logic [CNT_W-1:0] txn_count
`endif
);

   // Reject configurations the datapath cannot represent.
   if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
      $error("gray_code_subtractor_pipe: WIDTH must be >= 2 and CNT_W >= 1");
   end

   // Reflected-binary Gray to binary: each bit is the XOR of all Gray bits above and including it.
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] r;
      r[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         r[i] = r[i+1] ^ g[i];
      end
      return r;
   endfunction

   // Binary to reflected-binary Gray.
   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] n);
      return n ^ (n >> 1);
   endfunction

   // Zero-extended subtraction; the MSB of the result is the borrow out.
   function automatic logic [WIDTH:0] sub_borrow(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             c);
      return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
   endfunction

   logic             vld_p1_q, vld_p1_d;
   logic             vld_p2_q, vld_p2_d;
   logic             vld_p3_q, vld_p3_d;
   logic [WIDTH-1:0] a_bin_p1_q, a_bin_p1_d;
   logic [WIDTH-1:0] b_bin_p1_q, b_bin_p1_d;
   logic             bi_p1_q, bi_p1_d;
   logic [WIDTH-1:0] d_bin_p2_q, d_bin_p2_d;
   logic             bo_p2_q, bo_p2_d;
   logic [WIDTH-1:0] diff_p3_q, diff_p3_d;
   logic             bo_p3_q, bo_p3_d;
   logic             adv_p1, adv_p2, adv_p3;

   // Advance chain: a stage moves when it is empty or its successor moves; the last stage moves when the consumer takes it.
   always_comb begin
      adv_p3 = !vld_p3_q || out_ready;
      adv_p2 = !vld_p2_q || adv_p3;
      adv_p1 = !vld_p1_q || adv_p2;
   end

   assign in_ready = adv_p1;

   // Next-state for every stage; data only loads when a valid item moves in, so stalled or emptied stages keep their contents.
   always_comb begin
      vld_p1_d   = vld_p1_q;
      a_bin_p1_d = a_bin_p1_q;
      b_bin_p1_d = b_bin_p1_q;
      bi_p1_d    = bi_p1_q;
      vld_p2_d   = vld_p2_q;
      d_bin_p2_d = d_bin_p2_q;
      bo_p2_d    = bo_p2_q;
      vld_p3_d   = vld_p3_q;
      diff_p3_d  = diff_p3_q;
      bo_p3_d    = bo_p3_q;

      // S1: operand capture and Gray decode
      if (adv_p1) begin
         vld_p1_d = in_valid;
         if (in_valid) begin
            a_bin_p1_d = gray2bin(a);
            b_bin_p1_d = gray2bin(b);
            bi_p1_d    = bi;
         end
      end

      // S2: binary subtract with borrow
      if (adv_p2) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            {bo_p2_d, d_bin_p2_d} = sub_borrow(a_bin_p1_q, b_bin_p1_q, bi_p1_q);
         end
      end

      // S3: Gray encode, drives the outputs
      if (adv_p3) begin
         vld_p3_d = vld_p2_q;
         if (vld_p2_q) begin
            diff_p3_d = bin2gray(d_bin_p2_q);
            bo_p3_d   = bo_p2_q;
         end
      end
   end

   // Pipeline registers; reset flushes both valids and data so outputs read zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q   <= 1'b0;
         a_bin_p1_q <= '0;
         b_bin_p1_q <= '0;
         bi_p1_q    <= 1'b0;
         vld_p2_q   <= 1'b0;
         d_bin_p2_q <= '0;
         bo_p2_q    <= 1'b0;
         vld_p3_q   <= 1'b0;
         diff_p3_q  <= '0;
         bo_p3_q    <= 1'b0;
      end else begin
         vld_p1_q   <= vld_p1_d;
         a_bin_p1_q <= a_bin_p1_d;
         b_bin_p1_q <= b_bin_p1_d;
         bi_p1_q    <= bi_p1_d;
         vld_p2_q   <= vld_p2_d;
         d_bin_p2_q <= d_bin_p2_d;
         bo_p2_q    <= bo_p2_d;
         vld_p3_q   <= vld_p3_d;
         diff_p3_q  <= diff_p3_d;
         bo_p3_q    <= bo_p3_d;
      end
   end

   assign out_valid = vld_p3_q;
   assign diff      = diff_p3_q;
   assign bo        = bo_p3_q;

`ifdef DIFF_STATS_EN
   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic [CNT_W-1:0] txn_count_q, txn_count_d;

   // Count each output handshake.
   always_comb begin
      txn_count_d = txn_count_q;
      if (vld_p3_q && out_ready) begin
         txn_count_d = sat_inc(txn_count_q);
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txn_count_q <= '0;
      end else begin
         txn_count_q <= txn_count_d;
      end
   end

   assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_gray_code_subtractor_pipe.sv
// Scoreboard bench for gray_code_subtractor_pipe: the driver pushes the
// expected {bo, diff} on every input handshake, an independent monitor pops
// and compares on every output handshake and checks stall stability.
module tb_gray_code_subtractor_pipe;

   localparam int WIDTH = 4;
`ifdef DIFF_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bi;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bo;
`ifdef DIFF_STATS_EN
   logic [CNT_W-1:0] txn_count;
`endif

   gray_code_subtractor_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bo        (bo)
`ifdef DIFF_STATS_EN
      ,
      .txn_count (txn_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int             n_cmp  = 0;
   int             n_fail = 0;
   logic [WIDTH:0] sb_q[$];
   int             g2b[1 << WIDTH];
   bit             must_ready = 0;
   bit             rnd_done   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decode via an inverse table, subtract as integers, wrap, re-encode.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] xa,
                                            input logic [WIDTH-1:0] xb,
                                            input logic xbi);
      int d;
      int g;
      bit borrow;
      d = g2b[xa] - g2b[xb] - int'(xbi);
      borrow = (d < 0);
      if (borrow) d += (1 << WIDTH);
      g = d ^ (d >> 1);
      return {borrow, g[WIDTH-1:0]};
   endfunction

   // Present one transaction; call at posedge+1, returns at posedge+1 after the handshake edge.
   task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xbi);
      bit accepted;
      accepted = 0;
      in_valid = 1'b1;
      a = xa;
      b = xb;
      bi = xbi;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (must_ready && k == 0) check("in_ready_stream", 32'(in_ready), 32'd1);
         if (in_ready) begin
            accepted = 1;
            sb_q.push_back(model(xa, xb, xbi));
            break;
         end
         @(posedge clk);
         #1;
      end
      check("send_accept", 32'(accepted), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Single transaction into an empty pipe: 3-cycle latency and known result.
   task automatic directed(input string name, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xbi, input logic [WIDTH-1:0] ed, input logic eb);
      send(xa, xb, xbi);
      @(negedge clk);
      check({name, "_lat1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({name, "_lat2"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({name, "_lat3"}, 32'(out_valid), 32'd1);
      check({name, "_diff"}, 32'(diff), 32'(ed));
      check({name, "_bo"}, 32'(bo), 32'(eb));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #2;
         if (sb_q.size() == 0) break;
      end
      check("drain_empty", 32'(sb_q.size()), 32'd0);
      check("drain_no_extra", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: output handshakes against the scoreboard, stall stability, counter model.
   initial begin
      bit             prev_stall;
      logic [WIDTH-1:0] prev_diff;
      logic           prev_bo;
      logic [WIDTH:0] e;
      int             cnt_model;
      prev_stall = 0;
      prev_diff = '0;
      prev_bo = 1'b0;
      cnt_model = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0;
            cnt_model = 0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_diff", 32'(diff), 32'(prev_diff));
               check("stall_bo", 32'(bo), 32'(prev_bo));
            end
`ifdef DIFF_STATS_EN
            check("txn_count", 32'(txn_count), 32'(cnt_model));
`endif
            if (out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_output: got diff=0x%0h bo=%0d, expected no output", diff, bo);
               end else begin
                  e = sb_q.pop_front();
                  check("out_diff", 32'(diff), 32'(e[WIDTH-1:0]));
                  check("out_bo", 32'(bo), 32'(e[WIDTH]));
               end
               if (cnt_model < (1 << CNT_W) - 1) cnt_model++;
            end
            prev_stall = out_valid && !out_ready;
            prev_diff = diff;
            prev_bo = bo;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < (1 << WIDTH); n++) g2b[n ^ (n >> 1)] = n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      bi = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bo", 32'(bo), 32'd0);
`ifdef DIFF_STATS_EN
      check("rst_txn_count", 32'(txn_count), 32'd0);
`endif
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

      // Directed cases: 5-3, 3-5 wrap, 0-0-1 wrap
      directed("basic", 4'b0111, 4'b0010, 1'b0, 4'b0011, 1'b0);
      directed("wrap1", 4'b0010, 4'b0111, 1'b0, 4'b1001, 1'b1);
      directed("wrap2", 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b1);
      drain();

      // Exhaustive back-to-back stream at full rate
      must_ready = 1;
      for (int i = 0; i < (1 << (2 * WIDTH + 1)); i++) begin
         logic [2*WIDTH:0] v;
         v = (2*WIDTH+1)'(i);
         send(v[2*WIDTH:WIDTH+1], v[WIDTH:1], v[0]);
      end
      must_ready = 0;
      drain();

      // Backpressure: 6 transactions, consumer stalls 5 cycles from cycle 4
      fork
         begin
            for (int i = 0; i < 6; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("bp_in_ready_full", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Randomized traffic with random input gaps and random backpressure
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Reset mid-flight: two in flight, one parked at the output
      out_ready = 1'b0;
      send(4'b0111, 4'b0010, 1'b0);
      send(4'b0010, 4'b0111, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("mid_pre_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_bo", 32'(bo), 32'd0);
`ifdef DIFF_STATS_EN
      check("mid_rst_count", 32'(txn_count), 32'd0);
`endif
      sb_q.delete();
      @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_idle", 32'(out_valid), 32'd0);
      end
      check("post_rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Five completions; counter saturates when enabled
      for (int i = 0; i < 5; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      drain();
`ifdef DIFF_STATS_EN
      check("count_saturated", 32'(txn_count), 32'((1 << CNT_W) - 1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_code_subtractor_pipe.md
Name: gray_code_subtractor_pipe

Overview:
- Pipelined, handshaked Gray-code subtractor: diff = a - b - bi, with operands and result all in reflected binary Gray code.
- Inverse-direction companion to the combinational Gray-code adder; shares the gray2bin/bin2gray conversion functions.
- Sits between a valid/ready producer and consumer.
- Sustains one result per cycle under full-rate acceptance and stalls cleanly under backpressure.

Parameters:
- WIDTH, 4: operand/result width in bits (>= 2).
- CNT_W, 16: width of the transaction counter (optional feature only).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: a/b/bi are valid.
- in_ready, output, 1: block accepts the input this cycle.
- a, input, WIDTH: minuend, Gray-coded.
- b, input, WIDTH: subtrahend, Gray-coded.
- bi, input, 1: borrow in.
- out_valid, output, 1: diff/bo are valid.
- out_ready, input, 1: consumer accepts the output.
- diff, output, WIDTH: difference, Gray-coded, modulo 2^WIDTH.
- bo, output, 1: borrow out.
- txn_count, output, CNT_W: completed-output count (present only with DIFF_STATS_EN).

Behaviour:
- Reset (async assert, synchronous-safe deassert): all stage valids = 0, all stage data = 0, so out_valid=0, diff=0, bo=0, txn_count=0. in_ready=1 on the first clock after release.
- Pipeline stages (registers):
  - S1: a_bin = gray2bin(a), b_bin = gray2bin(b), bi captured.
  - S2: {borrow, d_bin} = {1'b0,a_bin} - {1'b0,b_bin} - bi, computed at WIDTH+1 bits; bo = MSB of the result.
  - S3: diff = bin2gray(d_bin), bo registered; S3 drives the outputs directly.
- Latency: 3 cycles from input handshake to out_valid when unstalled.
- Throughput: 1 transaction per cycle while out_ready=1.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Stage k advances when stage k is empty or stage k+1 advances this cycle; S3 advances when !out_valid || out_ready.
  - in_ready = !s1_valid || s1_advance, combinational from downstream state. No combinational path from in_valid to out_valid.
- Stall: out_valid=1 && out_ready=0 holds diff/bo stable; upstream stages keep data and fill bubbles. When all 3 stages are full, in_ready=0.
- Bubbles: a stage whose predecessor is empty and which advances becomes empty. Empty stages never produce out_valid.
- Simultaneous events: output handshake and input handshake in the same cycle with the pipe full → shift by one, no loss, no duplication.
- Wrap: a_bin < b_bin + bi → bo=1 and diff = Gray of (a_bin - b_bin - bi + 2^WIDTH).
- in_valid must not drop while in_ready=0 is not required: inputs not accepted are simply not captured.
- Reset mid-operation: all in-flight transactions are discarded, outputs immediately go to reset values, and no result appears after release.

Optional Feature:
- Macro: DIFF_STATS_EN.
- Defined:
  - txn_count port exists.
  - Increments by 1 on each output handshake and saturates at 2^CNT_W-1 (no wrap).
  - Cleared by rst_n only.
- Undefined:
  - Port and counter are absent.
  - Datapath and handshake timing are identical.

Test Plan:
- Basic, WIDTH=4, out_ready=1: a=0111 (5), b=0010 (3), bi=0 at cycle 0 → cycle 3: out_valid=1, diff=0011 (2), bo=0.
- Borrow wrap: a=0010 (3), b=0111 (5), bi=0 → diff=1001 (14), bo=1. Also a=0000, b=0000, bi=1 → diff=1000 (15), bo=1.
- Exhaustive streaming: all 16×16×2 combinations back-to-back with out_ready=1.
  - Results arrive in order, one per cycle after 3-cycle fill.
  - Each result matches the bin→subtract→Gray reference model.
  - in_ready never drops.
- Backpressure: stream 6 transactions, hold out_ready=0 from cycle 4 for 5 cycles.
  - in_ready=0 once 3 stages are full.
  - diff/bo are stable while stalled.
  - All 6 results are delivered in order after release, none duplicated.
- Reset mid-flight: accept 2 transactions, assert rst_n=0 asynchronously mid-cycle.
  - out_valid=0 and diff=0 immediately.
  - After release with no new input, out_valid stays 0 for 5 cycles.
- DIFF_STATS_EN, CNT_W=2: complete 5 transactions → txn_count reads 1, 2, 3, 3, 3. Reset returns it to 0.
